extern_bus_responder: RTL and testbench
=======================================

Name: extern_bus_responder

Overview:
- Slave end of the kernel's external data bus.
- Serves the kernel's RD/WR requests, which carry an 8-bit address and an 8-bit write value.
- Backs the bus with a 256x8 data RAM plus two memory-mapped I/O registers (input port, output port).
- Inserts a programmable number of wait states and returns read data with a one-cycle Ready_o strobe.
- Sits between the kernel top and the board-level I/O.

Parameters:
- WAIT_CYCLES, 1, wait states between request acceptance and completion (0..15).
- PORT_IN_ADDR, 8'hFE, read-only address returning PortIn_i.
- PORT_OUT_ADDR, 8'hFF, read/write address of the output port register.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- RDRequest_i  input  1  read request, level, held by requester until Ready_o.
- WRRequest_i  input  1  write request, level, held by requester until Ready_o.
- ExternAddr_i  input  8  transaction address.
- ExternVal_i  input  8  write data.
- ExternVal_o  output  8  read data, registered.
- Ready_o  output  1  one-cycle completion strobe.
- Busy_o  output  1  high while a transaction is in progress.
- Fault_o  output  1  sticky protocol-fault flag.
- PortIn_i  input  8  external input port.
- PortOut_o  output  8  external output port register.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - ExternVal_o=0, Ready_o=0, Busy_o=0, Fault_o=0, PortOut_o=0, wait counter=0.
  - RAM contents are not reset.
  - Reset has priority over all other activity. A transaction aborted by reset performs no write.
- States: IDLE, WAIT, DONE. Busy_o=1 in WAIT and DONE. Ready_o=1 only in DONE. Both are registered.
- IDLE:
  - Exactly one of RD/WR high at an edge: latch address, write data and operation into internal registers.
  - Then go to WAIT with counter=WAIT_CYCLES-1, or, if WAIT_CYCLES==0, perform the commit actions and go directly to DONE.
  - Both RD and WR high: Fault_o set to 1, no transaction, stay IDLE. Fault_o clears only on reset.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter is 0, perform the commit actions and go to DONE.
  - Request lines and ExternAddr_i/ExternVal_i are ignored in WAIT; only latched copies are used.
- Commit actions (on the edge entering DONE):
  - Write to PORT_OUT_ADDR: PortOut_o <= latched data.
  - Write to PORT_IN_ADDR: discarded, no side effect.
  - Write to any other address: RAM[addr] <= data.
  - Read of PORT_IN_ADDR: ExternVal_o <= PortIn_i, sampled at this edge.
  - Read of PORT_OUT_ADDR: ExternVal_o <= PortOut_o.
  - Read of any other address: ExternVal_o <= RAM[addr].
  - Writes leave ExternVal_o unchanged.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- Latency:
  - Request sampled at edge k; Ready_o is high for the single cycle following edge k+WAIT_CYCLES.
  - With WAIT_CYCLES=0, Ready_o is high the cycle after edge k.
  - Read data is valid on ExternVal_o in the Ready_o cycle and holds until the next read commits.
- Back-to-back: the requester drops the request in the Ready_o cycle. A request still high in the first IDLE cycle after DONE is accepted as a new transaction (minimum 2+WAIT_CYCLES cycles per access).
- Read-after-write to the same RAM address returns the newly written value.
- Address arithmetic: none. Full 8-bit decode, no wrap logic needed.

Test Plan:
- WAIT_CYCLES=1: write 0xA5 to 0x10, then read 0x10. Ready_o pulses exactly one cycle, 2 cycles after each request sample. ExternVal_o=0xA5 in the read's Ready_o cycle.
- Write 0x3C to 0xFF. PortOut_o becomes 0x3C on the DONE-entry edge. A subsequent read of 0xFF returns 0x3C.
- PortIn_i=0x5A, read 0xFE returns 0x5A. Write 0x77 to 0xFE, then read with PortIn_i=0x11 returns 0x11; PortOut_o and RAM are unchanged.
- WAIT_CYCLES=0 and WAIT_CYCLES=4: read latency is 1 and 5 cycles respectively. Busy_o is high from the acceptance edge until Ready_o falls.
- RD and WR both high in IDLE: Fault_o=1, Busy_o stays 0, no RAM/port change. Fault_o stays 1 through later normal transactions until rst.
- WAIT_CYCLES=3: write 0x99 to 0xFF, assert rst during WAIT. PortOut_o=0, no Ready_o pulse, state IDLE. A fresh read of 0xFF returns 0x00.

Source files
------------

// File: rtl/extern_bus_responder.sv
// Slave end of the kernel's external data bus. Serves single RD/WR accesses against a
// 256x8 data RAM plus an input-port and an output-port register, with a programmable
// number of wait states and a one-cycle Ready_o completion strobe.
module extern_bus_responder #(
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter logic [7:0]  PORT_IN_ADDR  = 8'hFE,
    parameter logic [7:0]  PORT_OUT_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RDRequest_i,
    input  logic       WRRequest_i,
    input  logic [7:0] ExternAddr_i,
    input  logic [7:0] ExternVal_i,
    output logic [7:0] ExternVal_o,
    output logic       Ready_o,
    output logic       Busy_o,
    output logic       Fault_o,
    input  logic [7:0] PortIn_i,
    output logic [7:0] PortOut_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    // Counter is loaded with WAIT_CYCLES-1; unused (zero) when no wait states are configured.
    localparam int unsigned WaitLoad = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]  CntLoad  = 4'(WaitLoad);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       write_q;
    logic       fault_q;
    logic [7:0] rdata_q;
    logic [7:0] port_out_q;
    logic [7:0] ram [256];

    logic       accept;
    logic       fault_set;
    logic       commit;
    logic       commit_write;
    logic [7:0] commit_addr;
    logic [7:0] commit_data;
    logic       commit_to_ram;

    // Next-state logic; commit operands come from the live bus only on a zero-wait accept.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        fault_set    = 1'b0;
        commit       = 1'b0;
        commit_addr  = addr_q;
        commit_data  = data_q;
        commit_write = write_q;
        unique case (state_q)
            StIdle: begin
                if (RDRequest_i ^ WRRequest_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit       = 1'b1;
                        commit_addr  = ExternAddr_i;
                        commit_data  = ExternVal_i;
                        commit_write = WRRequest_i;
                        state_d      = StDone;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end else if (RDRequest_i && WRRequest_i) begin
                    fault_set = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign commit_to_ram = commit && commit_write &&
                           (commit_addr != PORT_IN_ADDR) && (commit_addr != PORT_OUT_ADDR);

    // State, latched request, sticky fault, output port and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            write_q    <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 8'h00;
            port_out_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= ExternAddr_i;
                data_q  <= ExternVal_i;
                write_q <= WRRequest_i;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (commit) begin
                if (commit_write) begin
                    if (commit_addr == PORT_OUT_ADDR) begin
                        port_out_q <= commit_data;
                    end
                end else if (commit_addr == PORT_IN_ADDR) begin
                    rdata_q <= PortIn_i;
                end else if (commit_addr == PORT_OUT_ADDR) begin
                    rdata_q <= port_out_q;
                end else begin
                    rdata_q <= ram[commit_addr];
                end
            end
        end
    end

    // Data RAM write port; contents survive reset, but a reset edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit_to_ram) begin
            ram[commit_addr] <= commit_data;
        end
    end

    assign ExternVal_o = rdata_q;
    assign Ready_o     = (state_q == StDone);
    assign Busy_o      = (state_q != StIdle);
    assign Fault_o     = fault_q;
    assign PortOut_o   = port_out_q;

endmodule

// File: tb/tb_extern_bus_responder.sv
// Directed bench for extern_bus_responder: four instances with WAIT_CYCLES 1, 0, 4 and 3
// share the bus and reset; expected read data and latency go through a scoreboard queue.
module tb_extern_bus_responder;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [7:0] addr;
    logic [7:0] wval;
    logic [7:0] port_in;
    logic [7:0] val_o [4];
    logic [3:0] ready;
    logic [3:0] busy;
    logic [3:0] fault;
    logic [7:0] pout [4];

    int         n_assert;
    int         n_fail;
    int         wcyc [4];
    logic [7:0] model_ram [4][256];
    logic [7:0] model_port [4];
    logic [7:0] last_rd [4];
    exp_t       sb [$];

    extern_bus_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .RDRequest_i(rd[0]), .WRRequest_i(wr[0]),
        .ExternAddr_i(addr), .ExternVal_i(wval), .ExternVal_o(val_o[0]),
        .Ready_o(ready[0]), .Busy_o(busy[0]), .Fault_o(fault[0]),
        .PortIn_i(port_in), .PortOut_o(pout[0])
    );
    extern_bus_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .RDRequest_i(rd[1]), .WRRequest_i(wr[1]),
        .ExternAddr_i(addr), .ExternVal_i(wval), .ExternVal_o(val_o[1]),
        .Ready_o(ready[1]), .Busy_o(busy[1]), .Fault_o(fault[1]),
        .PortIn_i(port_in), .PortOut_o(pout[1])
    );
    extern_bus_responder #(.WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst(rst), .RDRequest_i(rd[2]), .WRRequest_i(wr[2]),
        .ExternAddr_i(addr), .ExternVal_i(wval), .ExternVal_o(val_o[2]),
        .Ready_o(ready[2]), .Busy_o(busy[2]), .Fault_o(fault[2]),
        .PortIn_i(port_in), .PortOut_o(pout[2])
    );
    extern_bus_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .RDRequest_i(rd[3]), .WRRequest_i(wr[3]),
        .ExternAddr_i(addr), .ExternVal_i(wval), .ExternVal_o(val_o[3]),
        .Ready_o(ready[3]), .Busy_o(busy[3]), .Fault_o(fault[3]),
        .PortIn_i(port_in), .PortOut_o(pout[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Model the access, push its expectation, run it on the bus and score the completion.
    task automatic txn(input int inst, input bit is_wr, input logic [7:0] a,
                       input logic [7:0] d);
        logic [7:0] e;
        exp_t       x;
        int         got;
        if (is_wr) begin
            if (a == 8'hFF) model_port[inst] = d;
            else if (a != 8'hFE) model_ram[inst][a] = d;
            e = last_rd[inst];
        end else begin
            if (a == 8'hFE) e = port_in;
            else if (a == 8'hFF) e = model_port[inst];
            else e = model_ram[inst][a];
            last_rd[inst] = e;
        end
        sb.push_back('{inst, e, wcyc[inst] + 1});
        @(negedge clk);
        addr = a;
        wval = d;
        rd[inst] = !is_wr;
        wr[inst] = is_wr;
        got = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy_during_txn i%0d", inst), 8'(busy[inst]), 8'h01);
            if (ready[inst]) begin
                got = i;
                break;
            end
        end
        rd[inst] = 1'b0;
        wr[inst] = 1'b0;
        x = sb.pop_front();
        chk($sformatf("latency i%0d a%h", x.inst, a), 8'(got), 8'(x.lat));
        chk($sformatf("rdata i%0d a%h", x.inst, a), val_o[x.inst], x.data);
        chk($sformatf("portout i%0d a%h", x.inst, a), pout[x.inst], model_port[x.inst]);
        @(posedge clk);
        #1;
        chk($sformatf("ready_one_cycle i%0d", inst), 8'(ready[inst]), 8'h00);
        chk($sformatf("busy_after i%0d", inst), 8'(busy[inst]), 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_port[i] = 8'h00;
            last_rd[i]    = 8'h00;
        end
    endtask

    initial begin
        bit seen_ready;
        n_assert = 0;
        n_fail   = 0;
        wcyc     = '{1, 0, 4, 3};
        rst      = 1'b1;
        rd       = 4'h0;
        wr       = 4'h0;
        addr     = 8'h00;
        wval     = 8'h00;
        port_in  = 8'h00;
        do_reset();

        // Reset state of every instance.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_val i%0d", i), val_o[i], 8'h00);
            chk($sformatf("rst_ready i%0d", i), 8'(ready[i]), 8'h00);
            chk($sformatf("rst_busy i%0d", i), 8'(busy[i]), 8'h00);
            chk($sformatf("rst_fault i%0d", i), 8'(fault[i]), 8'h00);
            chk($sformatf("rst_pout i%0d", i), pout[i], 8'h00);
        end

        // RAM write then read-back with one wait state.
        txn(0, 1'b1, 8'h10, 8'hA5);
        txn(0, 1'b0, 8'h10, 8'h00);
        // Output port write and read-back.
        txn(0, 1'b1, 8'hFF, 8'h3C);
        txn(0, 1'b0, 8'hFF, 8'h00);
        // Input port reads; a write to it has no side effect.
        port_in = 8'h5A;
        txn(0, 1'b0, 8'hFE, 8'h00);
        txn(0, 1'b1, 8'hFE, 8'h77);
        port_in = 8'h11;
        txn(0, 1'b0, 8'hFE, 8'h00);
        txn(0, 1'b0, 8'h10, 8'h00);
        txn(0, 1'b0, 8'hFF, 8'h00);

        // Zero and four wait states.
        txn(1, 1'b1, 8'h20, 8'h42);
        txn(1, 1'b0, 8'h20, 8'h00);
        txn(2, 1'b1, 8'h20, 8'hC3);
        txn(2, 1'b0, 8'h20, 8'h00);
        txn(2, 1'b1, 8'hFF, 8'h81);
        txn(2, 1'b0, 8'hFF, 8'h00);

        // Both requests high: sticky fault, no transaction.
        @(negedge clk);
        addr = 8'h10;
        wval = 8'hEE;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("fault_set", 8'(fault[0]), 8'h01);
        chk("fault_busy", 8'(busy[0]), 8'h00);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("fault_no_ready", 8'(ready[0]), 8'h00);
        chk("fault_pout", pout[0], model_port[0]);
        txn(0, 1'b0, 8'h10, 8'h00);
        chk("fault_sticky", 8'(fault[0]), 8'h01);

        // Reset during WAIT aborts a port write (three wait states).
        seen_ready = 1'b0;
        @(negedge clk);
        addr = 8'hFF;
        wval = 8'h99;
        wr[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy_accept", 8'(busy[3]), 8'h01);
        @(posedge clk);
        #1;
        seen_ready = seen_ready | ready[3];
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        seen_ready = seen_ready | ready[3];
        rst = 1'b0;
        wr[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_port[i] = 8'h00;
            last_rd[i]    = 8'h00;
        end
        chk("abort_pout", pout[3], 8'h00);
        chk("abort_busy", 8'(busy[3]), 8'h00);
        chk("abort_fault_cleared", 8'(fault[0]), 8'h00);
        repeat (5) begin
            @(posedge clk);
            #1;
            seen_ready = seen_ready | ready[3];
        end
        chk("abort_no_ready", 8'(seen_ready), 8'h00);
        chk("abort_pout_later", pout[3], 8'h00);
        txn(3, 1'b0, 8'hFF, 8'h00);
        // RAM contents survive reset.
        txn(0, 1'b0, 8'h10, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
